gsu_mem_ctrl: RTL

GSU-side memory responder for the SuperFX core. It accepts byte read/write requests from the GSU instruction/data path. It translates GSU bank/offset pairs into the same physical SRAM layout the SNES-side decoder produces: ROM at 0x000000 on SRAM0, gamepak RAM at 0xC00000 on SRAM1. It runs the request/acknowledge handshake with the memory arbiter and honours the SCMR RON/RAN bus-ownership bits.

---
 rtl/gsu_mem_ctrl_if.sv | 35 +++
 rtl/gsu_mem_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/gsu_mem_ctrl_if.sv
// Bus interfaces for gsu_mem_ctrl.
// gsu_bus_if: GSU instruction/data path (master) to the responder (slave).
// mem_bus_if: responder (master) to the memory arbiter (slave).
`timescale 1ns/1ps

interface gsu_bus_if;
  logic        gsu_req;
  logic        gsu_we;
  logic [7:0]  gsu_bank;
  logic [15:0] gsu_addr;
  logic [7:0]  gsu_wdata;
  logic [7:0]  gsu_rdata;
  logic        gsu_ack;
  logic        gsu_wait;

  modport master (output gsu_req, gsu_we, gsu_bank, gsu_addr, gsu_wdata,
                  input  gsu_rdata, gsu_ack, gsu_wait);
  modport slave  (input  gsu_req, gsu_we, gsu_bank, gsu_addr, gsu_wdata,
                  output gsu_rdata, gsu_ack, gsu_wait);
endinterface

interface mem_bus_if;
  logic        mem_req;
  logic        mem_we;
  logic        mem_sel;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  modport master (output mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ack);
  modport slave  (input  mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
                  output mem_rdata, mem_ack);
endinterface

// File: rtl/gsu_mem_ctrl.sv
// gsu_mem_ctrl: GSU-side memory responder for the SuperFX core.
// Maps GSU bank/offset pairs onto the shared SRAM layout (ROM on SRAM0,
// gamepak RAM at 0xC00000 on SRAM1), honours SCMR RON/RAN ownership and
// runs the req/ack handshake with the memory arbiter.
// Optional: define GSU_ROMBUF_EN to add a one-entry ROM read buffer.
`timescale 1ns/1ps

module gsu_mem_ctrl #(
  parameter logic [7:0] OOB_DATA = 8'hFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [23:0] ROM_MASK,
  input  logic        ron,
  input  logic        ran,
  gsu_bus_if.slave    gsu,
  mem_bus_if.master   mem
);

  typedef enum logic [2:0] {IDLE, CHECK, WAIT_OWN, ISSUE, WAIT_ACK, ACK} state_t;

  state_t      state, state_nx;
  logic [7:0]  cap_bank;
  logic [15:0] cap_addr;
  logic        cap_we;
  logic [7:0]  cap_wdata;
  logic        is_lorom, is_linear, is_rom, is_ram, owned;
  logic [23:0] phys_addr;
  logic        buf_hit;
  logic [7:0]  buf_data;
  logic        direct_ack, mem_done;
  logic [7:0]  rdata_q;
  logic        mem_req_q, mem_we_q, mem_sel_q;
  logic [23:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;

  // Decode the captured bank/offset into a region and a physical address.
  always_comb begin
    is_lorom  = ~cap_bank[6];
    is_linear = cap_bank[6] & ~cap_bank[5];
    is_rom    = is_lorom | is_linear;
    is_ram    = (cap_bank[7:1] == 7'b0111000);
    owned     = is_rom ? ron : ran;
    phys_addr = 24'h000000;
    if (is_lorom)
      phys_addr = {3'b000, cap_bank[5:0], cap_addr[14:0]} & ROM_MASK;
    else if (is_linear)
      phys_addr = {3'b000, cap_bank[4:0], cap_addr} & ROM_MASK;
    else if (is_ram)
      phys_addr = {7'b1100000, cap_bank[0], cap_addr};
  end

`ifdef GSU_ROMBUF_EN
  logic        buf_valid;
  logic [23:0] buf_tag;

  // Remember the last ROM read; forget it whenever the GSU lets go of the ROM bus.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      buf_valid <= 1'b0;
      buf_tag   <= 24'h000000;
      buf_data  <= 8'h00;
    end else if (mem_done && !cap_we && !mem_sel_q) begin
      buf_valid <= 1'b1;
      buf_tag   <= mem_addr_q;
      buf_data  <= mem.mem_rdata;
    end else if (!ron && !(state == WAIT_ACK && !mem_sel_q)) begin
      buf_valid <= 1'b0;
    end
  end

  assign buf_hit = buf_valid && is_rom && !cap_we && (buf_tag == phys_addr);
`else
  assign buf_hit  = 1'b0;
  assign buf_data = OOB_DATA;
`endif

  // Requests that never touch memory: unmapped, ROM writes and buffer hits.
  assign direct_ack = (state == CHECK) &&
                      (!(is_rom || is_ram) || (is_rom && cap_we) || buf_hit);
  assign mem_done   = (state == WAIT_ACK) && mem.mem_ack;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic for the request/ownership/memory handshake.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (gsu.gsu_req) state_nx = CHECK;
      CHECK:    if (direct_ack) state_nx = ACK;
                else if (!owned) state_nx = WAIT_OWN;
                else state_nx = ISSUE;
      WAIT_OWN: if (owned) state_nx = ISSUE;
      ISSUE:    state_nx = WAIT_ACK;
      WAIT_ACK: if (mem.mem_ack) state_nx = ACK;
      ACK:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Request capture, memory-side registers and read-data return.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cap_bank    <= 8'h00;
      cap_addr    <= 16'h0000;
      cap_we      <= 1'b0;
      cap_wdata   <= 8'h00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= 1'b0;
      mem_addr_q  <= 24'h000000;
      mem_wdata_q <= 8'h00;
      rdata_q     <= 8'h00;
    end else begin
      if (state == IDLE && gsu.gsu_req) begin
        cap_bank  <= gsu.gsu_bank;
        cap_addr  <= gsu.gsu_addr;
        cap_we    <= gsu.gsu_we;
        cap_wdata <= gsu.gsu_wdata;
      end
      if (state_nx == ISSUE && state != ISSUE) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= cap_we;
        mem_sel_q   <= is_ram;
        mem_addr_q  <= phys_addr;
        mem_wdata_q <= cap_wdata;
      end
      if (mem_done) begin
        mem_req_q <= 1'b0;
        if (!cap_we) rdata_q <= mem.mem_rdata;
      end
      if (direct_ack && !cap_we)
        rdata_q <= buf_hit ? buf_data : OOB_DATA;
    end
  end

  assign gsu.gsu_rdata = rdata_q;
  assign gsu.gsu_ack   = (state == ACK);
  assign gsu.gsu_wait  = (state != IDLE);
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_sel   = mem_sel_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule
